fetch_stage: RTL and testbench

//   Program-counter and instruction-fetch stage of the 2-stage RV32 core (F -> EX).

---
 rtl/fetch_stage.sv | 108 ++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC generation and instruction fetch for the 2-stage RV32 core.
// Holds the fetch PC and the EX-stage PC/valid flag and counts retired
// instructions. Branches and jumps are resolved in EX. On a taken branch or
// jump, the slot fetched in parallel is squashed, which costs one bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic [31:0]       inst_rdata,
  input  logic [1:0]        pcsrc,
  input  logic [1:0]        btype,
  input  logic [31:0]       alu_r,
  input  logic [31:0]       rs1_data,
  output logic [ADDR_W-1:0] inst_addr,
  output logic              inst_en,
  output logic [31:0]       instr_ex,
  output logic [31:0]       pc_ex,
  output logic [31:0]       pc4_ex,
  output logic              valid_ex,
  output logic              redirect,
  output logic [31:0]       instret
);

  typedef enum logic [1:0] {
    PC_SEQ  = 2'd0,
    PC_BR   = 2'd1,
    PC_JAL  = 2'd2,
    PC_JALR = 2'd3
  } pcsrc_e;

  typedef enum logic [1:0] {
    BR_EQZ   = 2'd0,
    BR_ONE   = 2'd1,
    BR_NEZ   = 2'd2,
    BR_NEVER = 2'd3
  } btype_e;

  logic [31:0] r_pc_f;
  logic [31:0] r_pc_ex;
  logic        r_valid_ex;
  logic [31:0] r_instret;

  logic [31:0] w_instr;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_i;
  logic        w_cond;
  logic        w_taken;
  logic [31:0] w_target;

  assign w_instr   = r_valid_ex ? inst_rdata : NOP_INSTR;
  assign inst_addr = r_pc_f[ADDR_W+1:2];
  assign inst_en   = ~stall;
  assign instr_ex  = w_instr;
  assign pc_ex     = r_pc_ex;
  assign pc4_ex    = r_pc_ex + 32'd4;
  assign valid_ex  = r_valid_ex;
  assign redirect  = w_taken;
  assign instret   = r_instret;

  // Decode immediates and resolve whether/where the EX instruction redirects fetch
  always_comb begin
    w_imm_b  = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                w_instr[11:8], 1'b0};
    w_imm_j  = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                w_instr[30:21], 1'b0};
    w_imm_i  = {{20{w_instr[31]}}, w_instr[31:20]};
    w_cond   = 1'b0;
    w_target = r_pc_ex;
    unique case (btype_e'(btype))
      BR_EQZ:   w_cond = (alu_r == '0);
      BR_ONE:   w_cond = (alu_r == 32'd1);
      BR_NEZ:   w_cond = (alu_r != '0);
      BR_NEVER: w_cond = 1'b0;
      default:  w_cond = 1'b0;
    endcase
    unique case (pcsrc_e'(pcsrc))
      PC_BR:   w_target = r_pc_ex + w_imm_b;
      PC_JAL:  w_target = r_pc_ex + w_imm_j;
      PC_JALR: w_target = rs1_data + w_imm_i;
      default: w_target = r_pc_ex;
    endcase
    w_target[1:0] = 2'b00;
    w_taken = r_valid_ex & (((pcsrc_e'(pcsrc) == PC_BR) & w_cond) |
                            (pcsrc_e'(pcsrc) == PC_JAL) |
                            (pcsrc_e'(pcsrc) == PC_JALR));
  end

  // Advance fetch PC, EX slot and retire counter unless stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_f     <= RESET_PC;
      r_pc_ex    <= '0;
      r_valid_ex <= 1'b0;
      r_instret  <= '0;
    end else if (!stall) begin
      r_pc_f     <= w_taken ? w_target : r_pc_f + 32'd4;
      r_pc_ex    <= r_pc_f;
      r_valid_ex <= ~w_taken;
      r_instret  <= r_instret + {31'd0, r_valid_ex};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized control inputs,
// checked against a transaction-level model of the fetch/EX pipeline.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [31:0] inst_rdata;
  logic [1:0]  pcsrc;
  logic [1:0]  btype;
  logic [31:0] alu_r;
  logic [31:0] rs1_data;
  logic [11:0] inst_addr;
  logic        inst_en;
  logic [31:0] instr_ex;
  logic [31:0] pc_ex;
  logic [31:0] pc4_ex;
  logic        valid_ex;
  logic        redirect;
  logic [31:0] instret;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mem [0:4095];

  // Model state
  logic [31:0] m_pc_f, m_pc_ex, m_instret, m_rdata;
  logic        m_valid;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (12),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .inst_rdata(inst_rdata),
    .pcsrc     (pcsrc),
    .btype     (btype),
    .alu_r     (alu_r),
    .rs1_data  (rs1_data),
    .inst_addr (inst_addr),
    .inst_en   (inst_en),
    .instr_ex  (instr_ex),
    .pc_ex     (pc_ex),
    .pc4_ex    (pc4_ex),
    .valid_ex  (valid_ex),
    .redirect  (redirect),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory; holds data while disabled
  always @(posedge clk) if (inst_en) inst_rdata <= mem[inst_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_target(input logic [1:0] ps, input logic [31:0] i,
                                             input logic [31:0] pc, input logic [31:0] rs);
    logic signed [12:0] b;
    logic signed [20:0] j;
    logic signed [11:0] im;
    logic [31:0] t;
    b  = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j  = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    im = i[31:20];
    case (ps)
      2'd1:    t = pc + 32'(b);
      2'd2:    t = pc + 32'(j);
      default: t = rs + 32'(im);
    endcase
    return t & ~32'h3;
  endfunction

  function automatic logic ref_cond(input logic [1:0] bt, input logic [31:0] r);
    case (bt)
      2'd0:    return r == 0;
      2'd1:    return r == 1;
      2'd2:    return r != 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc_f = 32'h0; m_pc_ex = 32'h0; m_valid = 1'b0; m_instret = 32'h0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_instr"},    instr_ex, NOP);
    check({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
    check({tag, "_valid"},    {31'd0, valid_ex}, 32'd0);
    check({tag, "_pc_ex"},    pc_ex, 32'h0);
    check({tag, "_instret"},  instret, 32'h0);
    check({tag, "_addr"},     {20'd0, inst_addr}, 32'h0);
  endtask

  // One clock: drive inputs, compare outputs against the model, advance both
  task automatic cycle(input logic st, input logic [1:0] ps, input logic [1:0] bt,
                       input logic [31:0] ar, input logic [31:0] rs);
    logic [31:0] ins, tgt;
    logic tk;
    stall = st; pcsrc = ps; btype = bt; alu_r = ar; rs1_data = rs;
    #1;
    ins = m_valid ? m_rdata : NOP;
    tgt = ref_target(ps, ins, m_pc_ex, rs);
    tk  = m_valid && (ps == 2'd2 || ps == 2'd3 || (ps == 2'd1 && ref_cond(bt, ar)));
    check("addr",     {20'd0, inst_addr}, {20'd0, m_pc_f[13:2]});
    check("inst_en",  {31'd0, inst_en}, {31'd0, ~st});
    check("instr_ex", instr_ex, ins);
    check("pc_ex",    pc_ex, m_pc_ex);
    check("pc4_ex",   pc4_ex, m_pc_ex + 32'd4);
    check("valid_ex", {31'd0, valid_ex}, {31'd0, m_valid});
    check("redirect", {31'd0, redirect}, {31'd0, tk});
    check("instret",  instret, m_instret);
    @(posedge clk);
    if (rst_n && !st) begin
      m_rdata   = mem[m_pc_f[13:2]];
      m_instret = m_instret + (m_valid ? 32'd1 : 32'd0);
      m_pc_ex   = m_pc_f;
      m_pc_f    = tk ? tgt : m_pc_f + 32'd4;
      m_valid   = ~tk;
    end
    #2;
  endtask

  // Pull reset low mid-cycle with a jump pending in EX, then release
  task automatic mid_reset(input string tag);
    stall = 1'b0; pcsrc = 2'd2; btype = 2'd3;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset(tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; pcsrc = 2'd0; btype = 2'd0; alu_r = '0; rs1_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = NOP;
    mem[4]    = 32'h0000_0463;  // beq x0,x0,+8 at 0x10
    mem[5]    = 32'h0000_0463;  // beq x0,x0,+8 at 0x14
    mem[7]    = 32'h0020_8067;  // jalr x0,2(x1) at 0x1C
    mem[8'h41] = 32'h01C0_006F; // jal x0,+0x1C at 0x104
    model_reset();
    #3;
    check_reset("rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // T1: sequential fetch from reset
    for (int i = 0; i < 4; i++) begin
      check("t1_addr", {20'd0, inst_addr}, i);
      cycle(1'b0, 2'd0, 2'd3, 32'h0, 32'h0);
    end
    check("t1_instret", instret, 32'd3);
    check("t1_pc_ex", pc_ex, 32'hC);
    cycle(1'b0, 2'd0, 2'd3, 32'h0, 32'h0);

    // T3: beq not taken at 0x10, no bubble
    check("t3_instr", instr_ex, 32'h0000_0463);
    cycle(1'b0, 2'd1, 2'd0, 32'd5, 32'h0);
    check("t3_pc_ex", pc_ex, 32'h14);
    check("t3_valid", {31'd0, valid_ex}, 32'd1);

    // T2: beq taken at 0x14 -> 0x1C with one bubble
    cycle(1'b0, 2'd1, 2'd0, 32'd0, 32'h0);
    check("t2_bubble_valid", {31'd0, valid_ex}, 32'd0);
    check("t2_bubble_instr", instr_ex, NOP);
    cycle(1'b0, 2'd1, 2'd0, 32'd0, 32'h0);
    check("t2_target", pc_ex, 32'h1C);

    // T4: jalr with rs1=0x103, imm=+2 -> 0x104
    check("t4_pc4", pc4_ex, 32'h20);
    cycle(1'b0, 2'd3, 2'd3, 32'h0, 32'h103);
    cycle(1'b0, 2'd0, 2'd3, 32'h0, 32'h0);
    check("t4_target", pc_ex, 32'h104);

    // T5: jal held under stall, acted on when stall drops
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd2, 2'd3, 32'h0, 32'h0);
    check("t5_pc_ex", pc_ex, 32'h104);
    check("t5_instret", instret, 32'd7);
    check("t5_addr", {20'd0, inst_addr}, 32'h42);
    cycle(1'b0, 2'd2, 2'd3, 32'h0, 32'h0);
    cycle(1'b0, 2'd0, 2'd3, 32'h0, 32'h0);
    check("t5_target", pc_ex, 32'h120);
    check("t5_instret2", instret, 32'd8);

    // T6: reset while a jump is taken
    mid_reset("t6");
    cycle(1'b0, 2'd0, 2'd3, 32'h0, 32'h0);
    check("t6_restart", pc_ex, 32'h0);
    check("t6_valid", {31'd0, valid_ex}, 32'd1);

    // Randomized control flow, stalls, and occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ar, rs;
      ar = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 2)) : $urandom;
      rs = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      if ($urandom_range(0, 299) == 0) mid_reset("rnd_rst");
      else cycle($urandom_range(0, 3) == 0, 2'($urandom), 2'($urandom), ar, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
